// File: rtl/cell_core_issue_pkg.sv
// Shared ISA definitions for the cell core: opcodes, instruction field layout
// and the register-writing opcode predicate.
package cell_core_issue_pkg;

  localparam logic [3:0] OpLi   = 4'd0;
  localparam logic [3:0] OpAdd  = 4'd1;
  localparam logic [3:0] OpSub  = 4'd2;
  localparam logic [3:0] OpAnd  = 4'd3;
  localparam logic [3:0] OpOr   = 4'd4;
  localparam logic [3:0] OpNor  = 4'd5;
  localparam logic [3:0] OpSeq  = 4'd6;
  localparam logic [3:0] OpSlt  = 4'd7;
  localparam logic [3:0] OpMul  = 4'd8;
  localparam logic [3:0] OpShr  = 4'd9;
  localparam logic [3:0] OpFmul = 4'd10;

  localparam int unsigned OpcodeLsb = 20;
  localparam int unsigned RdLsb     = 16;
  localparam int unsigned RsLsb     = 12;
  localparam int unsigned RtLsb     = 8;
  localparam int unsigned ImmLsb    = 0;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [7:0] imm;
  } instr_t;

  // Codes 11..15 are unassigned and retire as NOPs.
  function automatic logic writes_reg(input logic [3:0] opcode);
    case (opcode)
      OpLi, OpAdd, OpSub, OpAnd, OpOr, OpNor, OpSeq, OpSlt, OpMul, OpShr, OpFmul: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cell_core_regfile.sv
// Cell core register file: two operand read ports, one debug read port,
// one synchronous write port; all entries cleared by asynchronous reset.
module cell_core_regfile #(
  parameter int unsigned REGISTER_LENGTH = 32,
  parameter int unsigned NUM_REGS        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 raddr_a,
  input  logic [3:0]                 raddr_b,
  input  logic [3:0]                 dbg_addr,
  output logic [REGISTER_LENGTH-1:0] rdata_a,
  output logic [REGISTER_LENGTH-1:0] rdata_b,
  output logic [REGISTER_LENGTH-1:0] dbg_data,
  input  logic                       we,
  input  logic [3:0]                 waddr,
  input  logic [REGISTER_LENGTH-1:0] wdata
);

  logic [REGISTER_LENGTH-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs_q[raddr_a];
  assign rdata_b  = regs_q[raddr_b];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/cell_core_issue.sv
// Issue/writeback stage of the cell core. Define CELL_CORE_ISSUE_FORWARD_EN to
// bypass the in-flight ALU result into operands and accept one instruction per cycle.
module cell_core_issue
  import cell_core_issue_pkg::*;
#(
  parameter int unsigned REGISTER_LENGTH = 32,
  parameter int unsigned NUM_REGS        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [23:0]                instr,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  output logic [3:0]                 alu_opcode,
  output logic [7:0]                 alu_immediate,
  output logic [REGISTER_LENGTH-1:0] alu_first,
  output logic [REGISTER_LENGTH-1:0] alu_second,
  input  logic [REGISTER_LENGTH-1:0] alu_result,
  output logic                       retired,
  input  logic [3:0]                 dbg_addr,
  output logic [REGISTER_LENGTH-1:0] dbg_data
);

  instr_t                     dec;
  logic                       accept;
  logic [REGISTER_LENGTH-1:0] rf_a, rf_b;
  logic [REGISTER_LENGTH-1:0] op_first, op_second;

  logic                       iss_valid_q;
  logic [3:0]                 iss_opcode_q;
  logic [3:0]                 iss_rd_q;
  logic [7:0]                 iss_imm_q;
  logic [REGISTER_LENGTH-1:0] iss_first_q, iss_second_q;

  always_comb begin
    dec.opcode = instr[OpcodeLsb +: 4];
    dec.rd     = instr[RdLsb +: 4];
    dec.rs     = instr[RsLsb +: 4];
    dec.rt     = instr[RtLsb +: 4];
    dec.imm    = instr[ImmLsb +: 8];
  end

`ifdef CELL_CORE_ISSUE_FORWARD_EN
  logic fwd_live;

  assign instr_ready = 1'b1;
  assign fwd_live    = iss_valid_q && writes_reg(iss_opcode_q);
  // The instruction retiring this edge has not reached the register file yet.
  assign op_first    = (fwd_live && (iss_rd_q == dec.rs)) ? alu_result : rf_a;
  assign op_second   = (fwd_live && (iss_rd_q == dec.rt)) ? alu_result : rf_b;
`else
  assign instr_ready = !iss_valid_q;
  assign op_first    = rf_a;
  assign op_second   = rf_b;
`endif

  assign accept = instr_valid && instr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid_q  <= 1'b0;
      iss_opcode_q <= '0;
      iss_rd_q     <= '0;
      iss_imm_q    <= '0;
      iss_first_q  <= '0;
      iss_second_q <= '0;
    end else begin
      iss_valid_q <= accept;
      if (accept) begin
        iss_opcode_q <= dec.opcode;
        iss_rd_q     <= dec.rd;
        iss_imm_q    <= dec.imm;
        iss_first_q  <= op_first;
        iss_second_q <= op_second;
      end
    end
  end

  assign alu_opcode    = iss_opcode_q;
  assign alu_immediate = iss_imm_q;
  assign alu_first     = iss_first_q;
  assign alu_second    = iss_second_q;
  assign retired       = iss_valid_q;

  cell_core_regfile #(
    .REGISTER_LENGTH(REGISTER_LENGTH),
    .NUM_REGS       (NUM_REGS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (dec.rs),
    .raddr_b (dec.rt),
    .dbg_addr(dbg_addr),
    .rdata_a (rf_a),
    .rdata_b (rf_b),
    .dbg_data(dbg_data),
    .we      (iss_valid_q && writes_reg(iss_opcode_q)),
    .waddr   (iss_rd_q),
    .wdata   (alu_result)
  );

endmodule

// File: tb/tb_cell_core_issue.sv
// Self-checking bench for cell_core_issue: bench-side ALU plus an architectural
// register model updated once per retired instruction.
module tb_cell_core_issue;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [23:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    alu_opcode;
  logic [7:0]    alu_immediate;
  logic [W-1:0]  alu_first, alu_second, alu_result;
  logic          retired;
  logic [3:0]    dbg_addr;
  logic [W-1:0]  dbg_data;

  int            checks = 0;
  int            failures = 0;
  logic [W-1:0]  mregs [16];

  always #5 clk = ~clk;

  cell_core_issue #(
    .REGISTER_LENGTH(W),
    .NUM_REGS       (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .alu_opcode   (alu_opcode),
    .alu_immediate(alu_immediate),
    .alu_first    (alu_first),
    .alu_second   (alu_second),
    .alu_result   (alu_result),
    .retired      (retired),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [7:0] imm,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'd0:    return {{(W-8){imm[7]}}, imm};
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return ~(a | b);
      4'd6:    return (a == b) ? 32'd1 : 32'd0;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:    return a * b;
      4'd9:    return a >> b[4:0];
      4'd10:   return (a * b) ^ 32'h5A5A_0000;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_opcode, alu_immediate, alu_first, alu_second);

  function automatic logic [23:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs, input logic [3:0] rt,
                                     input logic [7:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction

  // Architectural effect of one instruction on the model.
  task automatic model_retire(input logic [23:0] w);
    logic [3:0] op, rd, rs, rt;
    op = w[23:20]; rd = w[19:16]; rs = w[15:12]; rt = w[11:8];
    if (op <= 4'd10) mregs[rd] = alu_fn(op, w[7:0], mregs[rs], mregs[rt]);
  endtask

  // Hold the word valid until it is accepted; returns 1ns after the accepting edge.
  task automatic send(input logic [23:0] w);
    bit ok;
    ok = 0;
    instr = w;
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (instr_ready === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout: instr=%h never accepted (ready=%b)", w, instr_ready);
    end
  endtask

  // Issue one word, then park at the falling edge of its retire cycle.
  task automatic exec(input logic [23:0] w);
    send(w);
    instr_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; instr_valid = 1'b0; instr = '0; dbg_addr = '0;
    #2;
    checks++; if (instr_ready !== 1'b1) begin failures++;
      $display("FAIL reset_ready: got %b want 1", instr_ready); end
    checks++; if (retired !== 1'b0) begin failures++;
      $display("FAIL reset_retired: got %b want 0", retired); end
    checks++; if ({alu_opcode, alu_immediate, alu_first, alu_second} !== '0) begin failures++;
      $display("FAIL reset_alu: got %h %h %h %h want 0", alu_opcode, alu_immediate,
               alu_first, alu_second); end
    #10 rst = 1'b0;
    for (int r = 0; r < 16; r++) mregs[r] = '0;
    @(posedge clk); #1;
    exec(mk(4'd0, 4'd7, 4'd0, 4'd0, 8'h11));
    model_retire(mk(4'd0, 4'd7, 4'd0, 4'd0, 8'h11));
    @(negedge clk);
    dbg_addr = 4'd7; #1;
    checks++; if (dbg_data !== 32'h11) begin failures++;
      $display("FAIL pre_reset_r7: got %h want 00000011", dbg_data); end
    // Reset lands while LI r7,0x22 sits in the issue register.
    send(mk(4'd0, 4'd7, 4'd0, 4'd0, 8'h22));
    instr_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++; if (retired !== 1'b0) begin failures++;
      $display("FAIL midreset_retired: got %b want 0", retired); end
    checks++; if ({alu_opcode, alu_immediate, alu_first, alu_second} !== '0) begin failures++;
      $display("FAIL midreset_alu: got %h %h %h %h want 0", alu_opcode, alu_immediate,
               alu_first, alu_second); end
    @(posedge clk); #1 rst = 1'b0;
    for (int r = 0; r < 16; r++) mregs[r] = '0;
    @(negedge clk);
    for (int r = 0; r < 16; r++) begin
      dbg_addr = r[3:0]; #1;
      checks++; if (dbg_data !== 32'h0) begin failures++;
        $display("FAIL midreset_reg r%0d: got %h want 0", r, dbg_data); end
    end
  endtask

  task automatic test_li;
    exec(mk(4'd0, 4'd3, 4'd0, 4'd0, 8'h21));
    model_retire(mk(4'd0, 4'd3, 4'd0, 4'd0, 8'h21));
    @(negedge clk);
    exec(mk(4'd0, 4'd3, 4'd0, 4'd0, 8'hF6));
    checks++; if (retired !== 1'b1 || alu_immediate !== 8'hF6 || alu_opcode !== 4'd0) begin
      failures++;
      $display("FAIL li_issue: retired=%b imm=%h op=%h want 1 f6 0", retired, alu_immediate,
               alu_opcode); end
    dbg_addr = 4'd3; #1;
    checks++; if (dbg_data !== 32'h21) begin failures++;
      $display("FAIL li_early: r3=%h want 00000021 before writeback", dbg_data); end
    model_retire(mk(4'd0, 4'd3, 4'd0, 4'd0, 8'hF6));
    @(negedge clk);
    checks++; if (dbg_data !== 32'hFFFF_FFF6 || retired !== 1'b0) begin failures++;
      $display("FAIL li_sext: r3=%h retired=%b want fffffff6 0", dbg_data, retired); end
  endtask

  task automatic test_add;
    exec(mk(4'd0, 4'd1, 4'd0, 4'd0, 8'd5));  model_retire(mk(4'd0, 4'd1, 4'd0, 4'd0, 8'd5));
    exec(mk(4'd0, 4'd2, 4'd0, 4'd0, 8'd7));  model_retire(mk(4'd0, 4'd2, 4'd0, 4'd0, 8'd7));
    exec(mk(4'd1, 4'd4, 4'd1, 4'd2, 8'd0));
    checks++; if (alu_opcode !== 4'd1 || alu_first !== 32'd5 || alu_second !== 32'd7) begin
      failures++;
      $display("FAIL add_operands: op=%h a=%h b=%h want 1 5 7", alu_opcode, alu_first,
               alu_second); end
    model_retire(mk(4'd1, 4'd4, 4'd1, 4'd2, 8'd0));
    @(negedge clk);
    dbg_addr = 4'd4; #1;
    checks++; if (dbg_data !== 32'd12) begin failures++;
      $display("FAIL add_result: r4=%h want 0000000c", dbg_data); end
  endtask

  task automatic test_back_to_back;
    exec(mk(4'd0, 4'd5, 4'd0, 4'd0, 8'h44)); model_retire(mk(4'd0, 4'd5, 4'd0, 4'd0, 8'h44));
    @(posedge clk); #1;
    instr = mk(4'd0, 4'd1, 4'd0, 4'd0, 8'd3);
    instr_valid = 1'b1;
    checks++; if (instr_ready !== 1'b1) begin failures++;
      $display("FAIL b2b_ready_idle: got %b want 1", instr_ready); end
    @(posedge clk); #1;
    instr = mk(4'd2, 4'd5, 4'd1, 4'd1, 8'd0);
    @(negedge clk);
`ifdef CELL_CORE_ISSUE_FORWARD_EN
    checks++; if (retired !== 1'b1 || alu_opcode !== 4'd0 || instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first: retired=%b op=%h ready=%b want 1 0 1", retired, alu_opcode,
               instr_ready); end
    model_retire(mk(4'd0, 4'd1, 4'd0, 4'd0, 8'd3));
    @(posedge clk); #1 instr_valid = 1'b0;
`else
    checks++; if (retired !== 1'b1 || alu_opcode !== 4'd0 || instr_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: retired=%b op=%h ready=%b want 1 0 0", retired, alu_opcode,
               instr_ready); end
    model_retire(mk(4'd0, 4'd1, 4'd0, 4'd0, 8'd3));
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (retired !== 1'b0 || instr_ready !== 1'b1) begin failures++;
      $display("FAIL b2b_bubble: retired=%b ready=%b want 0 1", retired, instr_ready); end
    @(posedge clk); #1 instr_valid = 1'b0;
`endif
    @(negedge clk);
    checks++; if (retired !== 1'b1 || alu_opcode !== 4'd2 || alu_first !== 32'd3 ||
                  alu_second !== 32'd3) begin
      failures++;
      $display("FAIL b2b_operands: retired=%b op=%h a=%h b=%h want 1 2 3 3", retired,
               alu_opcode, alu_first, alu_second); end
    model_retire(mk(4'd2, 4'd5, 4'd1, 4'd1, 8'd0));
    @(negedge clk);
    dbg_addr = 4'd5; #1;
    checks++; if (dbg_data !== 32'd0) begin failures++;
      $display("FAIL b2b_result: r5=%h want 0", dbg_data); end
  endtask

  task automatic test_reserved;
    exec(mk(4'd12, 4'd2, 4'd1, 4'd4, 8'h33));
    checks++; if (retired !== 1'b1 || alu_opcode !== 4'd12) begin failures++;
      $display("FAIL reserved_retire: retired=%b op=%h want 1 c", retired, alu_opcode); end
    @(negedge clk);
    dbg_addr = 4'd2; #1;
    checks++; if (dbg_data !== 32'd7) begin failures++;
      $display("FAIL reserved_nowrite: r2=%h want 00000007", dbg_data); end
  endtask

  task automatic test_backpressure;
    exec(mk(4'd1, 4'd6, 4'd1, 4'd2, 8'h5A));
    model_retire(mk(4'd1, 4'd6, 4'd1, 4'd2, 8'h5A));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (retired !== 1'b0 || alu_opcode !== 4'd1 || alu_immediate !== 8'h5A ||
                    alu_first !== 32'd3 || alu_second !== 32'd7) begin
        failures++;
        $display("FAIL idle_hold c%0d: retired=%b op=%h imm=%h a=%h b=%h want 0 1 5a 3 7", c,
                 retired, alu_opcode, alu_immediate, alu_first, alu_second); end
    end
    for (int r = 0; r < 16; r++) begin
      dbg_addr = r[3:0]; #1;
      checks++; if (dbg_data !== mregs[r]) begin failures++;
        $display("FAIL idle_reg r%0d: got %h want %h", r, dbg_data, mregs[r]); end
    end
  endtask

  task automatic test_random;
    logic [31:0] rnd;
    logic [23:0] w;
    logic [W-1:0] exp_a, exp_b;
    for (int n = 0; n < 60; n++) begin
      rnd = $urandom;
      w = rnd[23:0];
      exp_a = mregs[w[15:12]];
      exp_b = mregs[w[11:8]];
      exec(w);
      checks++; if (retired !== 1'b1 || alu_opcode !== w[23:20] || alu_immediate !== w[7:0] ||
                    alu_first !== exp_a || alu_second !== exp_b) begin
        failures++;
        $display("FAIL rand_issue n%0d instr=%h: retired=%b op=%h imm=%h a=%h b=%h want a=%h b=%h",
                 n, w, retired, alu_opcode, alu_immediate, alu_first, alu_second, exp_a, exp_b);
      end
      model_retire(w);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);
    for (int r = 0; r < 16; r++) begin
      dbg_addr = r[3:0]; #1;
      checks++; if (dbg_data !== mregs[r]) begin failures++;
        $display("FAIL rand_reg r%0d: got %h want %h", r, dbg_data, mregs[r]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_li();
    test_add();
    test_back_to_back();
    test_reserved();
    test_backpressure();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
